control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
Hardwired control unit that drives the datapath's register-transfer control inputs: it fetches each instruction, decodes the IR, and issues the T-state control pulses.
It is the producer end of the control interface the datapath consumes.
Covers fetch plus register-register ALU, MUL/DIV, NEG/NOT, NOP and HALT.
Memory reads use a ready handshake so the memory block can insert wait states.

Parameters:
NREGS, 16, number of general registers; sets width of the Rin/Rout one-hot vectors.
OPW, 5, opcode field width; the opcode occupies IR[31:27].

Ports:
clock  in  1  system clock, rising-edge.
clear  in  1  reset; asynchronous, active-low.
run  in  1  level; 1 permits fetching the next instruction.
IR  in  32  current IR register value from the datapath.
mem_ready  in  1  memory read data valid this cycle.
Rin  out  16  one-hot general-register load (R0in..R15in).
Rout  out  16  one-hot general-register drive (R0out..R15out).
PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin  out  1 each  datapath strobes.
alu_sel  out  13  one-hot ALU op: b0 ADD, b1 SUB, b2 AND, b3 OR, b4 SHR, b5 SHRA, b6 SHL, b7 ROR, b8 ROL, b9 NEG, b10 NOT, b11 MUL, b12 DIV.
busy  out  1  high in every state except IDLE and HALTED.
halted  out  1  high in HALTED.
illegal  out  1  sticky; set when HALTED was entered on an undefined opcode.

Behaviour:
- Reset (clear=0, async): state=IDLE, illegal=0. All outputs are 0 immediately, including mid-instruction.
- Outputs are combinational decode of the state register and IR only. There is no input-to-output path except as listed below. IDLE decodes to all-zero.
- Register fields: Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]. Rin/Rout are one-hot of the selected field. R0 gets no special treatment.
- Opcodes (package constants): ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010, NOP 11010, HALT 11011. All others are illegal.
- IDLE: if run=1, go to T0 next edge; otherwise stay.
- T0: PCout, IncPC, MARin, Zin, alu_sel=0. Go to T1.
- T1: Zlowout, PCin, Read, MDRin.
  - These are held every cycle while mem_ready=0. The PC reload is idempotent.
  - Go to T2 on the edge where mem_ready=1.
- T2: MDRout, IRin. Go to T3.
- T3, decoded from the new IR:
  - ALU two-operand ops and MUL/DIV: Rout=Rb, Yin. Go to T4.
  - NEG/NOT: go straight to T4; no output asserted in T3.
  - NOP: go to END.
  - HALT: go to HALTED.
  - Illegal: set illegal=1, go to HALTED.
- T4, two-operand ops: Rout=Rc, alu_sel=op, Zin.
- T4, NEG/NOT: Rout=Rb, alu_sel=op, Zin.
- T5, MUL/DIV: Zlowout, LOin. Go to T6.
- T5, all other ops: Zlowout, Rin=Ra. Go to END.
- T6: Zhighout, HIin. Go to END.
- END is a zero-cycle decision taken on the last T-state edge: next state is T0 if run=1, otherwise IDLE.
- Latency with mem_ready tied 1: ALU/NEG/NOT 6 cycles, MUL/DIV 7, NOP 4.
- HALTED: all strobes 0, halted=1. Exited only by reset; run is ignored.
- run falling mid-instruction has no effect; the instruction completes.

Optional Feature:
CTRL_SINGLE_STEP_EN
- Defined: adds input port step (1 bit). IDLE→T0 requires run=1 and step=1 in the same cycle, and END always returns to IDLE. One instruction executes per step pulse.
- Undefined: no step port; behaviour exactly as above.

Decomposition:
- Package ctrl_pkg holds:
  - state enum (IDLE, T0..T6, HALTED);
  - opcode constants;
  - alu_sel bit indices;
  - IR field bit positions.
- One sub-module, reg_field_decoder: a 4-to-16 one-hot decoder with enable, instantiated twice (Rin, Rout).

Test Plan:
- IR=0x18918000 (add R1,R2,R3), run=1, mem_ready=1 → the following 6 consecutive cycles, then T0 again:
  - T0: PCout/IncPC/MARin/Zin;
  - T1: Read/MDRin/PCin/Zlowout;
  - T2: MDRout/IRin;
  - T3: Rout=0x0004, Yin;
  - T4: Rout=0x0008, alu_sel=0x0001, Zin;
  - T5: Zlowout, Rin=0x0002.
- IR=0x782B0000 (mul R5,R6) → T3 Rout=0x0020; T4 Rout=0x0040, alu_sel=0x0800; T5 LOin+Zlowout; T6 HIin+Zhighout; 7 cycles total.
- mem_ready held 0 for 3 cycles in T1 → Read, MDRin and PCin stay high for 4 cycles; T2 follows the cycle after mem_ready=1.
- IR=0xD8000000 (halt) → HALTED after T3; halted=1, illegal=0, busy=0. Toggling run changes nothing.
- IR=0xF8000000 (illegal) → halted=1, illegal=1.
- clear driven low mid-T4 → every output 0 the same instant, with no clock edge needed. After release with run=1, the fetch restarts at T0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for control_sequencer: T-state enum, opcodes,
// ALU-select bit positions, IR field positions and opcode classification helpers.
package ctrl_pkg;

    localparam int unsigned NREGS = 16;
    localparam int unsigned RSELW = 4;
    localparam int unsigned OPW   = 5;
    localparam int unsigned IRW   = 32;
    localparam int unsigned ALUW  = 13;

    localparam int unsigned OP_LSB = 27;
    localparam int unsigned RA_LSB = 23;
    localparam int unsigned RB_LSB = 19;
    localparam int unsigned RC_LSB = 15;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALTED
    } state_e;

    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
    localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
    localparam logic [OPW-1:0] OP_SHR  = 5'b01001;
    localparam logic [OPW-1:0] OP_SHRA = 5'b01010;
    localparam logic [OPW-1:0] OP_SHL  = 5'b01011;
    localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    localparam int unsigned ALU_ADD  = 0;
    localparam int unsigned ALU_SUB  = 1;
    localparam int unsigned ALU_AND  = 2;
    localparam int unsigned ALU_OR   = 3;
    localparam int unsigned ALU_SHR  = 4;
    localparam int unsigned ALU_SHRA = 5;
    localparam int unsigned ALU_SHL  = 6;
    localparam int unsigned ALU_ROR  = 7;
    localparam int unsigned ALU_ROL  = 8;
    localparam int unsigned ALU_NEG  = 9;
    localparam int unsigned ALU_NOT  = 10;
    localparam int unsigned ALU_MUL  = 11;
    localparam int unsigned ALU_DIV  = 12;

    // Single-bit datapath strobes, grouped as one payload
    typedef struct packed {
        logic pc_out;
        logic pc_in;
        logic inc_pc;
        logic mar_in;
        logic read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic zlow_out;
        logic zhigh_out;
        logic hi_in;
        logic lo_in;
    } strobes_t;

    function automatic logic [ALUW-1:0] alu_onehot(input logic [OPW-1:0] op);
        logic [ALUW-1:0] sel;
        sel = '0;
        case (op)
            OP_ADD:  sel[ALU_ADD]  = 1'b1;
            OP_SUB:  sel[ALU_SUB]  = 1'b1;
            OP_AND:  sel[ALU_AND]  = 1'b1;
            OP_OR:   sel[ALU_OR]   = 1'b1;
            OP_SHR:  sel[ALU_SHR]  = 1'b1;
            OP_SHRA: sel[ALU_SHRA] = 1'b1;
            OP_SHL:  sel[ALU_SHL]  = 1'b1;
            OP_ROR:  sel[ALU_ROR]  = 1'b1;
            OP_ROL:  sel[ALU_ROL]  = 1'b1;
            OP_NEG:  sel[ALU_NEG]  = 1'b1;
            OP_NOT:  sel[ALU_NOT]  = 1'b1;
            OP_MUL:  sel[ALU_MUL]  = 1'b1;
            OP_DIV:  sel[ALU_DIV]  = 1'b1;
            default: sel = '0;
        endcase
        return sel;
    endfunction

    function automatic logic is_muldiv(input logic [OPW-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_unary(input logic [OPW-1:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    // Ops that read Rb into Y in T3 and Rc in T4
    function automatic logic is_two_op(input logic [OPW-1:0] op);
        return (alu_onehot(op) != '0) && !is_unary(op);
    endfunction

endpackage

// File: rtl/control_sequencer_reg_field_decoder.sv
// 4-to-16 (generally W-to-N) one-hot decoder with enable, used for the Rin/Rout selects.
module reg_field_decoder #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 4
) (
    input  logic         en_i,
    input  logic [W-1:0] sel_i,
    output logic [N-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state control unit: fetch, decode and register-transfer strobes.
// Build option CTRL_SINGLE_STEP_EN adds a step input gating each instruction start.
module control_sequencer
    import ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic             run,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [IRW-1:0]   IR,
    input  logic             mem_ready,
    output logic [NREGS-1:0] Rin,
    output logic [NREGS-1:0] Rout,
    output logic             PCout,
    output logic             PCin,
    output logic             IncPC,
    output logic             MARin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             HIin,
    output logic             LOin,
    output logic [ALUW-1:0]  alu_sel,
    output logic             busy,
    output logic             halted,
    output logic             illegal
);

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    strobes_t   stb;
    logic       rin_en, rout_en;
    logic [RSELW-1:0] rin_sel, rout_sel;
    logic       start_ok;
    state_e     end_state;

    logic [OPW-1:0]   opcode;
    logic [RSELW-1:0] ra, rb, rc;
    logic             unused_ir;

    assign opcode    = IR[OP_LSB +: OPW];
    assign ra        = IR[RA_LSB +: RSELW];
    assign rb        = IR[RB_LSB +: RSELW];
    assign rc        = IR[RC_LSB +: RSELW];
    assign unused_ir = ^IR[RC_LSB-1:0];

    // Instruction start gate and the END decision target
`ifdef CTRL_SINGLE_STEP_EN
    assign start_ok  = run & step;
    assign end_state = ST_IDLE;
`else
    assign start_ok  = run;
    assign end_state = run ? ST_T0 : ST_IDLE;
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= ST_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        stb       = '0;
        alu_sel   = '0;
        rin_en    = 1'b0;
        rin_sel   = ra;
        rout_en   = 1'b0;
        rout_sel  = rb;
        halted    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) state_d = ST_T0;
            end
            ST_T0: begin
                stb.pc_out = 1'b1;
                stb.inc_pc = 1'b1;
                stb.mar_in = 1'b1;
                stb.z_in   = 1'b1;
                state_d    = ST_T1;
            end
            // Held through memory wait states; reloading PC from Z is harmless
            ST_T1: begin
                stb.zlow_out = 1'b1;
                stb.pc_in    = 1'b1;
                stb.read     = 1'b1;
                stb.mdr_in   = 1'b1;
                if (mem_ready) state_d = ST_T2;
            end
            ST_T2: begin
                stb.mdr_out = 1'b1;
                stb.ir_in   = 1'b1;
                state_d     = ST_T3;
            end
            ST_T3: begin
                if (is_two_op(opcode)) begin
                    rout_en  = 1'b1;
                    rout_sel = rb;
                    stb.y_in = 1'b1;
                    state_d  = ST_T4;
                end else if (is_unary(opcode)) begin
                    state_d = ST_T4;
                end else if (opcode == OP_NOP) begin
                    state_d = end_state;
                end else if (opcode == OP_HALT) begin
                    state_d = ST_HALTED;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALTED;
                end
            end
            ST_T4: begin
                rout_en  = 1'b1;
                rout_sel = is_unary(opcode) ? rb : rc;
                alu_sel  = alu_onehot(opcode);
                stb.z_in = 1'b1;
                state_d  = ST_T5;
            end
            ST_T5: begin
                stb.zlow_out = 1'b1;
                if (is_muldiv(opcode)) begin
                    stb.lo_in = 1'b1;
                    state_d   = ST_T6;
                end else begin
                    rin_en  = 1'b1;
                    rin_sel = ra;
                    state_d = end_state;
                end
            end
            ST_T6: begin
                stb.zhigh_out = 1'b1;
                stb.hi_in     = 1'b1;
                state_d       = end_state;
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    assign illegal = illegal_q;

    assign PCout    = stb.pc_out;
    assign PCin     = stb.pc_in;
    assign IncPC    = stb.inc_pc;
    assign MARin    = stb.mar_in;
    assign Read     = stb.read;
    assign MDRin    = stb.mdr_in;
    assign MDRout   = stb.mdr_out;
    assign IRin     = stb.ir_in;
    assign Yin      = stb.y_in;
    assign Zin      = stb.z_in;
    assign Zlowout  = stb.zlow_out;
    assign Zhighout = stb.zhigh_out;
    assign HIin     = stb.hi_in;
    assign LOin     = stb.lo_in;

    reg_field_decoder #(.N(NREGS), .W(RSELW)) u_rin_dec (
        .en_i     (rin_en),
        .sel_i    (rin_sel),
        .onehot_o (Rin)
    );

    reg_field_decoder #(.N(NREGS), .W(RSELW)) u_rout_dec (
        .en_i     (rout_en),
        .sel_i    (rout_sel),
        .onehot_o (Rout)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues per-cycle expected
// outputs, a negedge monitor pops and compares.
module tb_control_sequencer;

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic [12:0] alu;
        logic [13:0] stb;
        logic        busy;
        logic        halted;
        logic        illegal;
    } obs_t;

    localparam logic [13:0] SB_PCOUT  = 14'h2000;
    localparam logic [13:0] SB_PCIN   = 14'h1000;
    localparam logic [13:0] SB_INCPC  = 14'h0800;
    localparam logic [13:0] SB_MARIN  = 14'h0400;
    localparam logic [13:0] SB_READ   = 14'h0200;
    localparam logic [13:0] SB_MDRIN  = 14'h0100;
    localparam logic [13:0] SB_MDROUT = 14'h0080;
    localparam logic [13:0] SB_IRIN   = 14'h0040;
    localparam logic [13:0] SB_YIN    = 14'h0020;
    localparam logic [13:0] SB_ZIN    = 14'h0010;
    localparam logic [13:0] SB_ZLOW   = 14'h0008;
    localparam logic [13:0] SB_ZHIGH  = 14'h0004;
    localparam logic [13:0] SB_HIIN   = 14'h0002;
    localparam logic [13:0] SB_LOIN   = 14'h0001;

    localparam logic [31:0] IR_ADD  = 32'h1891_8000;  // add R1,R2,R3
    localparam logic [31:0] IR_MUL  = 32'h782B_0000;  // mul R5,R6
    localparam logic [31:0] IR_NOP  = 32'hD000_0000;
    localparam logic [31:0] IR_NEG  = 32'h8BC8_0000;  // neg R7,R9
    localparam logic [31:0] IR_HALT = 32'hD800_0000;
    localparam logic [31:0] IR_ILL  = 32'hF800_0000;

    logic        clock;
    logic        clear;
    logic        run;
    logic [31:0] IR;
    logic        mem_ready;
    logic [15:0] Rin, Rout;
    logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic [12:0] alu_sel;
    logic        busy, halted, illegal;
`ifdef CTRL_SINGLE_STEP_EN
    logic        step = 1'b1;
`endif

    control_sequencer dut (
        .clock     (clock),
        .clear     (clear),
        .run       (run),
`ifdef CTRL_SINGLE_STEP_EN
        .step      (step),
`endif
        .IR        (IR),
        .mem_ready (mem_ready),
        .Rin       (Rin),
        .Rout      (Rout),
        .PCout     (PCout),
        .PCin      (PCin),
        .IncPC     (IncPC),
        .MARin     (MARin),
        .Read      (Read),
        .MDRin     (MDRin),
        .MDRout    (MDRout),
        .IRin      (IRin),
        .Yin       (Yin),
        .Zin       (Zin),
        .Zlowout   (Zlowout),
        .Zhighout  (Zhighout),
        .HIin      (HIin),
        .LOin      (LOin),
        .alu_sel   (alu_sel),
        .busy      (busy),
        .halted    (halted),
        .illegal   (illegal)
    );

    obs_t act;
    assign act = {Rin, Rout, alu_sel,
                  PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
                  Yin, Zin, Zlowout, Zhighout, HIin, LOin,
                  busy, halted, illegal};

    int    checks = 0;
    int    errors = 0;
    obs_t  exp_q[$];
    string name_q[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic obs_t mk(input logic [15:0] rin, input logic [15:0] rout,
                                input logic [12:0] alu, input logic [13:0] stb,
                                input logic bsy, input logic hlt, input logic ill);
        obs_t o;
        o = '{rin: rin, rout: rout, alu: alu, stb: stb, busy: bsy, halted: hlt, illegal: ill};
        return o;
    endfunction

    function automatic void chk(input string nm, input obs_t got, input obs_t e);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, e);
        end
    endfunction

    // Push expectation for the current cycle, then advance to the next posedge+1
    task automatic cyc(input obs_t e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input string tag);
        cyc(mk(16'h0, 16'h0, 13'h0, SB_PCOUT | SB_INCPC | SB_MARIN | SB_ZIN, 1'b1, 1'b0, 1'b0), {tag, "_t0"});
        cyc(mk(16'h0, 16'h0, 13'h0, SB_ZLOW | SB_PCIN | SB_READ | SB_MDRIN, 1'b1, 1'b0, 1'b0), {tag, "_t1"});
        cyc(mk(16'h0, 16'h0, 13'h0, SB_MDROUT | SB_IRIN, 1'b1, 1'b0, 1'b0), {tag, "_t2"});
    endtask

    // Monitor: compares DUT outputs against the queue head every cycle
    initial begin
        obs_t  e;
        string nm;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk(nm, act, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t e_idle, e_busy0, e_t1, e_halt;
        e_idle  = mk(16'h0, 16'h0, 13'h0, 14'h0, 1'b0, 1'b0, 1'b0);
        e_busy0 = mk(16'h0, 16'h0, 13'h0, 14'h0, 1'b1, 1'b0, 1'b0);
        e_t1    = mk(16'h0, 16'h0, 13'h0, SB_ZLOW | SB_PCIN | SB_READ | SB_MDRIN, 1'b1, 1'b0, 1'b0);
        e_halt  = mk(16'h0, 16'h0, 13'h0, 14'h0, 1'b0, 1'b1, 1'b0);

        clear = 1'b0; run = 1'b0; mem_ready = 1'b1; IR = 32'h0;
        @(posedge clock);
        #1;
        cyc(e_idle, "reset0");
        cyc(e_idle, "reset1");
        clear = 1'b1;
        cyc(e_idle, "idle_run0");

        // ADD, back-to-back with run dropping during the second instance
        IR = IR_ADD; run = 1'b1;
        cyc(e_idle, "add_pre");
        fetch("add");
        cyc(mk(16'h0, 16'h0004, 13'h0, SB_YIN, 1'b1, 1'b0, 1'b0), "add_t3");
        cyc(mk(16'h0, 16'h0008, 13'h0001, SB_ZIN, 1'b1, 1'b0, 1'b0), "add_t4");
        cyc(mk(16'h0002, 16'h0, 13'h0, SB_ZLOW, 1'b1, 1'b0, 1'b0), "add_t5");
        run = 1'b0;
        fetch("add2");
        cyc(mk(16'h0, 16'h0004, 13'h0, SB_YIN, 1'b1, 1'b0, 1'b0), "add2_t3");
        cyc(mk(16'h0, 16'h0008, 13'h0001, SB_ZIN, 1'b1, 1'b0, 1'b0), "add2_t4");
        cyc(mk(16'h0002, 16'h0, 13'h0, SB_ZLOW, 1'b1, 1'b0, 1'b0), "add2_t5");
        cyc(e_idle, "add2_end");

        // MUL: seven cycles, HI/LO writeback
        IR = IR_MUL; run = 1'b1;
        cyc(e_idle, "mul_pre");
        run = 1'b0;
        fetch("mul");
        cyc(mk(16'h0, 16'h0020, 13'h0, SB_YIN, 1'b1, 1'b0, 1'b0), "mul_t3");
        cyc(mk(16'h0, 16'h0040, 13'h0800, SB_ZIN, 1'b1, 1'b0, 1'b0), "mul_t4");
        cyc(mk(16'h0, 16'h0, 13'h0, SB_ZLOW | SB_LOIN, 1'b1, 1'b0, 1'b0), "mul_t5");
        cyc(mk(16'h0, 16'h0, 13'h0, SB_ZHIGH | SB_HIIN, 1'b1, 1'b0, 1'b0), "mul_t6");
        cyc(e_idle, "mul_end");

        // NOP with three memory wait states in T1
        IR = IR_NOP; run = 1'b1;
        cyc(e_idle, "nop_pre");
        run = 1'b0; mem_ready = 1'b0;
        cyc(mk(16'h0, 16'h0, 13'h0, SB_PCOUT | SB_INCPC | SB_MARIN | SB_ZIN, 1'b1, 1'b0, 1'b0), "nop_t0");
        cyc(e_t1, "nop_t1_w0");
        cyc(e_t1, "nop_t1_w1");
        cyc(e_t1, "nop_t1_w2");
        mem_ready = 1'b1;
        cyc(e_t1, "nop_t1_rdy");
        cyc(mk(16'h0, 16'h0, 13'h0, SB_MDROUT | SB_IRIN, 1'b1, 1'b0, 1'b0), "nop_t2");
        cyc(e_busy0, "nop_t3");
        cyc(e_idle, "nop_end");

        // NEG: T3 silent, T4 drives Rb
        IR = IR_NEG; run = 1'b1;
        cyc(e_idle, "neg_pre");
        run = 1'b0;
        fetch("neg");
        cyc(e_busy0, "neg_t3");
        cyc(mk(16'h0, 16'h0200, 13'h0200, SB_ZIN, 1'b1, 1'b0, 1'b0), "neg_t4");
        cyc(mk(16'h0080, 16'h0, 13'h0, SB_ZLOW, 1'b1, 1'b0, 1'b0), "neg_t5");
        cyc(e_idle, "neg_end");

        // HALT: run is ignored once halted
        IR = IR_HALT; run = 1'b1;
        cyc(e_idle, "halt_pre");
        fetch("halt");
        cyc(e_busy0, "halt_t3");
        cyc(e_halt, "halted0");
        run = 1'b0;
        cyc(e_halt, "halted_run0");
        run = 1'b1;
        cyc(e_halt, "halted_run1");
        clear = 1'b0;
        cyc(e_idle, "clr_halted");

        // Asynchronous clear in the middle of T4
        clear = 1'b1; IR = IR_ADD; run = 1'b1;
        cyc(e_idle, "add3_pre");
        fetch("add3");
        cyc(mk(16'h0, 16'h0004, 13'h0, SB_YIN, 1'b1, 1'b0, 1'b0), "add3_t3");
        exp_q.push_back(mk(16'h0, 16'h0008, 13'h0001, SB_ZIN, 1'b1, 1'b0, 1'b0));
        name_q.push_back("add3_t4");
        #6;
        clear = 1'b0;
        #1;
        chk("clr_async", act, e_idle);
        @(posedge clock);
        #1;

        // Restart from T0 after release, then an undefined opcode
        clear = 1'b1; IR = IR_ILL; run = 1'b1;
        cyc(e_idle, "rst_release");
        fetch("restart");
        cyc(e_busy0, "ill_t3");
        run = 1'b0;
        cyc(mk(16'h0, 16'h0, 13'h0, 14'h0, 1'b0, 1'b1, 1'b1), "ill_halted");
        cyc(mk(16'h0, 16'h0, 13'h0, 14'h0, 1'b0, 1'b1, 1'b1), "ill_halted2");

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
